// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-side memory arbiter.
// Pure declarations: no timing of its own.
// No flow control here; consumers apply the lock mask to gate requests.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam int   LOCK_MAX_DEF = 15;
    localparam int   LCNT_W_DEF   = 4;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    // Which masters may be granted in a given FSM state (bit i = master i).
    function automatic logic [1:0] lock_mask(input arb_state_t st);
        logic [1:0] m;
        case (st)
            ST_IDLE:  m = 2'b11;
            ST_LOCK0: m = 2'b01;
            ST_LOCK1: m = 2'b10;
            default:  m = 2'b00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker producing a one-hot grant.
// Purely combinational, zero latency.
// Masked-out requesters simply see no grant and must keep requesting.
module mem_arbiter_rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_rr,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);

    logic [1:0] w_elig;

    assign w_elig = i_req & i_mask;

    // On contention favour the master that was not granted last.
    always_comb begin
        o_gnt = 2'b00;
        if (w_elig == 2'b11) begin
            o_gnt = i_rr ? 2'b01 : 2'b10;
        end else begin
            o_gnt = w_elig;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory port between the LSU (m0) and a secondary master (m1), with bus lock and watchdog.
// Grant and downstream command are same-cycle; read data returns one cycle after the read grant.
// A locked-out or losing master sees gnt=0 and must hold its request stable until granted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int LCNT_W   = LCNT_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m0_lock_i,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_lock_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic [31:0] m1_rdata_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_wr_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic        mem_rd_en_o,
    output logic [31:0] mem_rd_addr_o,
    input  logic [31:0] mem_rd_data_i,
    output logic        lock_err_o
);

    localparam logic [LCNT_W-1:0] LP_LOCK_MAX = LCNT_W'(LOCK_MAX);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [LCNT_W-1:0] r_lock_cnt;
    logic [LCNT_W-1:0] w_lock_cnt_nxt;
    logic              r_rr;
    logic              r_rd_vld;
    logic              r_rd_tag;
    logic [31:0]       r_m0_rdata;
    logic [31:0]       r_m1_rdata;

    logic [1:0]        w_mask;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_sel;
    logic              w_we;
    logic              w_lock;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;

    // Grants are suppressed entirely while reset is asserted.
    assign w_mask = rst_i ? lock_mask(r_state) : 2'b00;

    mem_arbiter_rr_pick2 u_pick (
        .i_req  ({m1_req_i, m0_req_i}),
        .i_rr   (r_rr),
        .i_mask (w_mask),
        .o_gnt  (w_gnt)
    );

    assign m0_gnt_o = w_gnt[0];
    assign m1_gnt_o = w_gnt[1];
    assign w_any    = |w_gnt;
    assign w_sel    = w_gnt[1];

    assign w_we    = (w_sel == MST_M1) ? m1_we_i    : m0_we_i;
    assign w_lock  = (w_sel == MST_M1) ? m1_lock_i  : m0_lock_i;
    assign w_addr  = (w_sel == MST_M1) ? m1_addr_i  : m0_addr_i;
    assign w_wdata = (w_sel == MST_M1) ? m1_wdata_i : m0_wdata_i;

    // Downstream command is zeroed whenever nothing is granted.
    assign mem_wr_en_o   = w_any & w_we;
    assign mem_wr_addr_o = mem_wr_en_o ? w_addr  : 32'h0;
    assign mem_wr_data_o = mem_wr_en_o ? w_wdata : 32'h0;
    assign mem_rd_en_o   = w_any & ~w_we;
    assign mem_rd_addr_o = mem_rd_en_o ? w_addr  : 32'h0;

    // Lock entry on a locking grant; exit on the owner's unlocking grant or watchdog expiry.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = '0;
        lock_err_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && w_lock) begin
                    w_state_nxt = (w_sel == MST_M1) ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                // Only the owner can be granted here, so any grant is the owner's.
                if (w_any && !w_lock) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_lock_cnt == LP_LOCK_MAX) begin
                    w_state_nxt = ST_IDLE;
                    lock_err_o  = 1'b1;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state and watchdog counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Round-robin pointer remembers the last granted master; m1 at reset so m0 wins first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rr <= MST_M1;
        end else if (w_any) begin
            r_rr <= w_sel;
        end
    end

    // Read-return tag and per-master hold registers for returned data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_vld   <= 1'b0;
            r_rd_tag   <= MST_M0;
            r_m0_rdata <= 32'h0;
            r_m1_rdata <= 32'h0;
        end else begin
            r_rd_vld <= mem_rd_en_o;
            r_rd_tag <= w_sel;
            if (r_rd_vld && (r_rd_tag == MST_M0)) begin
                r_m0_rdata <= mem_rd_data_i;
            end
            if (r_rd_vld && (r_rd_tag == MST_M1)) begin
                r_m1_rdata <= mem_rd_data_i;
            end
        end
    end

    assign m0_rvalid_o = r_rd_vld & (r_rd_tag == MST_M0);
    assign m1_rvalid_o = r_rd_vld & (r_rd_tag == MST_M1);
    assign m0_rdata_o  = m0_rvalid_o ? mem_rd_data_i : r_m0_rdata;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rd_data_i : r_m1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a rule-level reference model predicts grants,
// downstream commands, read returns and lock timeouts; a negedge monitor checks them.
// A small memory model answers the DUT's downstream reads.
module tb_mem_arbiter;

    localparam int LOCK_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m0_lock_i, m1_req_i, m1_we_i, m1_lock_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_wr_en_o, mem_rd_en_o, lock_err_o;
    logic [31:0] mem_wr_addr_o, mem_wr_data_o, mem_rd_addr_o, mem_rd_data_i;

    mem_arbiter #(.LOCK_MAX(LOCK_MAX), .LCNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
        .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .lock_err_o(lock_err_o)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int m; bit we; logic [31:0] addr; logic [31:0] data; } gx_t;
    typedef struct { int cyc; int m; logic [31:0] data; } rx_t;

    gx_t gq[$];
    rx_t rdq[$];
    int  errq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Master stimulus state (held stable until the model says granted).
    bit          m_req[2];
    bit          m_we[2];
    bit          m_lk[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wd[2];

    // Reference model state.
    int owner = -1;
    int held  = 0;
    int last  = 1;
    int granted = -1;
    logic [31:0] ref_mem [logic [31:0]];

    // Environment memory, driven only by what the DUT actually issued.
    logic [31:0] env_mem [logic [31:0]];
    bit          env_wr_en, env_rd_en;
    logic [31:0] env_wr_addr, env_wr_data, env_rd_addr;

    logic [31:0] hold[2];
    gx_t mon_e;
    rx_t mon_r;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic set_m(input int i, input bit rq, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit lk);
        m_req[i] = rq; m_we[i] = we; m_addr[i] = a; m_wd[i] = d; m_lk[i] = lk;
    endtask

    task automatic mk(input int i, input bit rq, input bit lk_ok);
        set_m(i, rq, 1'($urandom_range(0, 1)), 32'h100 + 4 * $urandom_range(0, 7), $urandom,
              lk_ok && ($urandom_range(0, 99) < 15));
    endtask

    // Drive this cycle's requests and predict the arbiter's response from its rules.
    task automatic drive_and_model();
        bit el0, el1;
        int g;
        gx_t e;
        rx_t r;
        m0_req_i = m_req[0]; m0_we_i = m_we[0]; m0_addr_i = m_addr[0];
        m0_wdata_i = m_wd[0]; m0_lock_i = m_lk[0];
        m1_req_i = m_req[1]; m1_we_i = m_we[1]; m1_addr_i = m_addr[1];
        m1_wdata_i = m_wd[1]; m1_lock_i = m_lk[1];
        el0 = m_req[0] && (owner < 0 || owner == 0);
        el1 = m_req[1] && (owner < 0 || owner == 1);
        g = -1;
        if (el0 && el1) g = 1 - last;
        else if (el0) g = 0;
        else if (el1) g = 1;
        granted = g;
        if (g >= 0) begin
            last = g;
            e.cyc = cyc; e.m = g; e.we = m_we[g]; e.addr = m_addr[g]; e.data = m_wd[g];
            gq.push_back(e);
            if (m_we[g]) begin
                ref_mem[m_addr[g]] = m_wd[g];
            end else begin
                r.cyc = cyc + 1; r.m = g;
                r.data = ref_mem.exists(m_addr[g]) ? ref_mem[m_addr[g]] : init_val(m_addr[g]);
                rdq.push_back(r);
            end
        end
        if (owner >= 0) begin
            if (g == owner && !m_lk[g]) begin
                owner = -1;
            end else if (held == LOCK_MAX) begin
                errq.push_back(cyc);
                owner = -1;
            end else begin
                held++;
            end
        end else if (g >= 0 && m_lk[g]) begin
            owner = g;
            held = 0;
        end
    endtask

    // Advance to just after the next rising edge and let the memory model respond.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (env_wr_en) env_mem[env_wr_addr] = env_wr_data;
        if (env_rd_en)
            mem_rd_data_i = env_mem.exists(env_rd_addr) ? env_mem[env_rd_addr] : init_val(env_rd_addr);
        else
            mem_rd_data_i = $urandom;
    endtask

    task automatic step();
        drive_and_model();
        next_cycle();
        if (granted >= 0) m_req[granted] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk($sformatf("%s_ctl", tag),
            {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, lock_err_o, mem_wr_en_o, mem_rd_en_o}, 0);
        chk($sformatf("%s_addr", tag), {mem_wr_addr_o, mem_rd_addr_o}, 0);
        chk($sformatf("%s_wdata", tag), mem_wr_data_o, 0);
        chk($sformatf("%s_rdata", tag), {m0_rdata_o, m1_rdata_o}, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, rvalid or lock error.
    always @(negedge clk) begin
        env_wr_en   = mem_wr_en_o;  env_wr_addr = mem_wr_addr_o; env_wr_data = mem_wr_data_o;
        env_rd_en   = mem_rd_en_o;  env_rd_addr = mem_rd_addr_o;
        if (!rst_i) begin
            hold[0] = 32'h0;
            hold[1] = 32'h0;
        end else begin
            if (m0_gnt_o || m1_gnt_o) begin
                chk("gnt_onehot", m0_gnt_o & m1_gnt_o, 0);
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {m1_gnt_o, m0_gnt_o}, 0);
                end else begin
                    mon_e = gq.pop_front();
                    chk("gnt_cycle", cyc, mon_e.cyc);
                    chk("gnt_master", {m1_gnt_o, m0_gnt_o}, mon_e.m ? 2'b10 : 2'b01);
                    chk("wr_en", mem_wr_en_o, mon_e.we);
                    chk("wr_addr", mem_wr_addr_o, mon_e.we ? mon_e.addr : 32'h0);
                    chk("wr_data", mem_wr_data_o, mon_e.we ? mon_e.data : 32'h0);
                    chk("rd_en", mem_rd_en_o, !mon_e.we);
                    chk("rd_addr", mem_rd_addr_o, mon_e.we ? 32'h0 : mon_e.addr);
                end
            end else begin
                chk("idle_bus", {mem_wr_en_o, mem_rd_en_o, mem_wr_addr_o, mem_wr_data_o, mem_rd_addr_o}, 0);
                if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                    mon_e = gq.pop_front();
                    chk("gnt_missing", {m1_gnt_o, m0_gnt_o}, mon_e.m ? 2'b10 : 2'b01);
                end
            end
            if (m0_rvalid_o || m1_rvalid_o) begin
                chk("rvalid_onehot", m0_rvalid_o & m1_rvalid_o, 0);
                if (rdq.size() == 0) begin
                    chk("rvalid_unexpected", {m1_rvalid_o, m0_rvalid_o}, 0);
                end else begin
                    mon_r = rdq.pop_front();
                    chk("rvalid_cycle", cyc, mon_r.cyc);
                    chk("rvalid_master", {m1_rvalid_o, m0_rvalid_o}, mon_r.m ? 2'b10 : 2'b01);
                    chk("rdata", mon_r.m ? m1_rdata_o : m0_rdata_o, mon_r.data);
                    hold[mon_r.m] = mon_r.data;
                end
            end else if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
                mon_r = rdq.pop_front();
                chk("rvalid_missing", {m1_rvalid_o, m0_rvalid_o}, mon_r.m ? 2'b10 : 2'b01);
            end
            if (!m0_rvalid_o) chk("rdata_hold0", m0_rdata_o, hold[0]);
            if (!m1_rvalid_o) chk("rdata_hold1", m1_rdata_o, hold[1]);
            if (lock_err_o) begin
                if (errq.size() == 0) chk("lock_err_unexpected", lock_err_o, 0);
                else chk("lock_err_cycle", cyc, errq.pop_front());
            end else if (errq.size() > 0 && errq[0] <= cyc) begin
                void'(errq.pop_front());
                chk("lock_err_missing", lock_err_o, 1);
            end
        end
    end

    initial begin
        rst_i = 1'b0;
        mem_rd_data_i = 32'h0;
        set_m(0, 1'b1, 1'b1, 32'h100, 32'h1111_1111, 1'b1);
        set_m(1, 1'b1, 1'b0, 32'h104, 32'h0, 1'b0);
        drive_and_model();   // model state is reset below; this only drives the pins
        gq.delete(); rdq.delete(); errq.delete(); owner = -1; held = 0; last = 1;
        #3;
        check_zero("reset_state");
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_i = 1'b1;
        next_cycle();

        // Concurrent reads after reset: m0 first, then m1.
        set_m(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        set_m(1, 1'b1, 1'b0, 32'h0010_0020, 32'h0, 1'b0);
        repeat (3) step();

        // Write pass-through, then read-back by m0.
        set_m(1, 1'b1, 1'b1, 32'h0010_0004, 32'hDEAD_BEEF, 1'b0);
        step();
        set_m(0, 1'b1, 1'b0, 32'h0010_0004, 32'h0, 1'b0);
        repeat (2) step();

        // AMO lock by m0 while m1 keeps requesting.
        set_m(0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1);
        step();
        set_m(1, 1'b1, 1'b1, 32'h200, 32'h2222_2222, 1'b0);
        repeat (2) step();
        set_m(0, 1'b1, 1'b1, 32'h200, 32'h3333_3333, 1'b0);
        repeat (3) step();

        // Lock watchdog: m0 locks and goes quiet, m1 waits.
        set_m(0, 1'b1, 1'b0, 32'h204, 32'h0, 1'b1);
        step();
        set_m(1, 1'b1, 1'b0, 32'h204, 32'h0, 1'b0);
        repeat (LOCK_MAX + 2) step();
        repeat (2) step();

        // Reset while in LOCK1 with a read in flight.
        set_m(1, 1'b1, 1'b0, 32'h208, 32'h0, 1'b1);
        step();
        set_m(1, 1'b1, 1'b0, 32'h20C, 32'h0, 1'b1);
        set_m(0, 1'b1, 1'b1, 32'h210, 32'h4444_4444, 1'b0);
        drive_and_model();
        @(negedge clk); #2;
        rst_i = 1'b0;
        gq.delete(); rdq.delete(); errq.delete(); owner = -1; held = 0; last = 1;
        #1;
        check_zero("reset_mid");
        @(posedge clk); #1;
        check_zero("reset_hold");
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        @(negedge clk); #2;
        rst_i = 1'b1;
        next_cycle();
        set_m(1, 1'b1, 1'b0, 32'h20C, 32'h0, 1'b0);
        repeat (3) step();

        // Round-robin fairness under continuous contention.
        mk(0, 1'b1, 1'b0);
        mk(1, 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            step();
            if (granted >= 0) mk(granted, 1'b1, 1'b0);
        end

        // Randomized traffic with locks and occasional watchdog expiry.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_req[i]) mk(i, ($urandom_range(0, 99) < ((owner == i) ? 8 : 55)), 1'b1);
            end
            step();
        end

        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        repeat (LOCK_MAX + 4) step();
        chk("gq_drained", gq.size(), 0);
        chk("rdq_drained", rdq.size(), 0);
        chk("errq_drained", errq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single data-side memory port of `memory_top` between the core load/store unit (m0) and a secondary master such as DMA or debug (m1). It issues at most one access per cycle, read or write, and uses round-robin fairness. It supports a bus lock for atomic read-modify-write sequences (RV32A AMO, LR/SC) and enforces a watchdog on held locks. It sits between the masters and the `mem_wr_*` / `mem_rd_*` inputs of `memory_top`.

## Interface
Parameters:
- `LOCK_MAX`, default 15: maximum number of cycles a lock may be held before it is force-released.
- `LCNT_W`, default 4: width of the lock counter. Must satisfy 2^`LCNT_W` > `LOCK_MAX`.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `m0_req_i`, `m1_req_i`  in  1  access request.
- `m0_we_i`, `m1_we_i`  in  1  1 = write, 0 = read.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_wdata_i`, `m1_wdata_i`  in  32  write data.
- `m0_lock_i`, `m1_lock_i`  in  1  hold the bus after this access.
- `m0_gnt_o`, `m1_gnt_o`  out  1  access accepted this cycle.
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  read data valid.
- `m0_rdata_o`, `m1_rdata_o`  out  32  read data.
- `mem_wr_en_o`  out  1  downstream write enable.
- `mem_wr_addr_o`  out  32  downstream write address.
- `mem_wr_data_o`  out  32  downstream write data.
- `mem_rd_en_o`  out  1  downstream read enable.
- `mem_rd_addr_o`  out  32  downstream read address.
- `mem_rd_data_i`  in  32  downstream read data, valid the cycle after `mem_rd_en_o`.
- `lock_err_o`  out  1  one-cycle pulse on a lock timeout.

## Operation
- **States:** `IDLE`, `LOCK0`, `LOCK1`. The round-robin pointer `rr_q` names the last granted master; its reset value is 1, so m0 wins first.
- **`IDLE`:**
  - Single request: that master is granted.
  - Both requesting: grant goes to the master that is not `rr_q`.
  - A granted access with lock=1 moves the FSM to `LOCKx` for the owner and clears `lock_cnt`.
- **`LOCKx`:**
  - Only master x can be granted; the other master's gnt is held at 0.
  - A granted access by x with lock=0 is the unlocking access and returns the FSM to `IDLE`.
  - A granted access by x with lock=1 keeps `LOCKx`.
  - x deasserting req does not release the lock.
- **Watchdog:**
  - `lock_cnt` increments every cycle spent in `LOCKx`.
  - When `lock_cnt` == `LOCK_MAX` and no unlocking grant occurs that cycle, the FSM goes to `IDLE` and `lock_err_o` pulses.
  - The owner's access in that same cycle, if any, is still granted.
- **`rr_q` update:** `rr_q` takes the granted master index on every grant.
- **Downstream command:**
  - Issued in the same cycle as gnt, driven combinationally from the granted master.
  - Write: `mem_wr_en_o`=1, with `mem_wr_addr_o`/`mem_wr_data_o` taken from the granted master.
  - Read: `mem_rd_en_o`=1, with `mem_rd_addr_o` taken from the granted master.
  - No grant: all downstream enables, addresses and data are 0.
- **Read return:**
  - A registered owner tag records which master issued the read.
  - `mx_rvalid_o`=1 in the cycle after a granted read, and `mx_rdata_o`=`mem_rd_data_i` in that cycle.
  - At all other times `mx_rdata_o` holds the last data returned to that master.
- **Write data width:** writes are full 32-bit. Byte/halfword merging is the LSU's responsibility.

## Timing
- **Grant:** gnt is combinational from req, FSM state and `rr_q`. Zero-cycle acceptance.
- **Throughput:** one access per cycle. Back-to-back grants to alternating masters are allowed.
- **Latency:** write completes at the grant edge; read returns 1 cycle after grant.
- **Reset:** `rst_i`=0 asynchronously forces the following, including mid-lock or with a read in flight:
  - FSM=`IDLE`, `rr_q`=1, `lock_cnt`=0.
  - All gnt, rvalid, `lock_err_o` and `mem_*_o` outputs = 0; both rdata registers = 0.
  - An in-flight read produces no rvalid.
- **Locked requester:** a request from the locked-out master stays pending with gnt=0. The master must hold req, addr, we and wdata stable until granted.
- **Simultaneous unlock:** an unlocking access and a request from the other master in the same cycle are resolved as follows: the owner is granted this cycle, and the other master is granted next cycle, ahead of round-robin.

## Structure
- FSM state encodings, `LOCK_MAX` default and master index constants go in the shared define header `mem_def.v`, alongside the memory map defines.
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin picker taking req[1:0], `rr_q` and a lock mask, producing a one-hot grant.
- The FSM, lock counter and read-return registers live in `mem_arbiter`.

## Test plan
- **Concurrent reads after reset:** both masters read, m0 at 0x0000_0010, m1 at 0x0010_0020.
  - m0 gnt in cycle 0, m1 gnt in cycle 1.
  - Each rvalid follows its grant by 1 cycle, with the matching data.
- **Write pass-through:** m1 writes 0xDEADBEEF to 0x0010_0004 alone.
  - `mem_wr_en_o`=1 in the same cycle with that address and data.
  - m0 read of the same address next cycle returns 0xDEADBEEF.
- **AMO lock:** m0 issues a lock read, then a write with lock=0, while m1 requests continuously.
  - m1 gnt stays 0 until the cycle after the unlocking write, then m1 is granted.
- **Lock watchdog:** m0 locks, then idles 16 cycles with `LOCK_MAX`=15.
  - `lock_err_o` pulses once; m1 is granted the following cycle.
- **Reset mid-flight:** assert `rst_i` low while in `LOCK1` with a read in flight.
  - All outputs are 0 immediately and no rvalid appears.
  - After release, m0 wins first.
- **Round-robin fairness:** both masters request continuously for 8 cycles.
  - Grants strictly alternate m0, m1, m0, ...
